// File: rtl/nes_joypad_pkg.sv
// ============================================================================
// Module : nes_joypad_pkg
// Brief  : Shared state encoding and button index constants for the NES pad
//          reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nes_joypad_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_CLK_LO = 3'd2;
  localparam logic [2:0] ST_CLK_HI = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LATCH  = ST_LATCH,
    CLK_LO = ST_CLK_LO,
    CLK_HI = ST_CLK_HI,
    DONE   = ST_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : One-bit two-flop synchronizer; resets to 1 (idle level of a pad).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/nes_joypad_reader.sv
// ============================================================================
// Module : nes_joypad_reader
// Brief  : Polls two NES pads over latch/clock/data and presents button bytes.
//          Optional macro JOYPAD_DEBOUNCE_EN: update only on two equal polls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nes_joypad_reader
  import nes_joypad_pkg::*;
#(
  parameter int PULSE_CYCLES = 150,
  parameter int POLL_CYCLES  = 416667,
  parameter int CNT_W        = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       pad_data_1,
  input  logic       pad_data_2,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] joycon_1,
  output logic [7:0] joycon_2,
  output logic       busy,
  output logic       valid
);

  localparam int PH_W = (2 * PULSE_CYCLES > 1) ? $clog2(2 * PULSE_CYCLES) : 1;
  localparam logic [PH_W-1:0]  LATCH_LAST  = PH_W'(2 * PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PULSE_LAST  = PH_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic [2:0]               bit_q, bit_d;
  logic [CNT_W-1:0]         timer_q, timer_d;
  logic [NUM_BUTTONS-1:0]   sh1_q, sh1_d, sh2_q, sh2_d;
  logic [NUM_BUTTONS-1:0]   joy1_q, joy1_d, joy2_q, joy2_d;
  logic                     data1_sync, data2_sync;
  logic                     start;

  sync_2ff u_sync_1 (.clk(clk), .rst(rst), .d_i(pad_data_1), .q_o(data1_sync));
  sync_2ff u_sync_2 (.clk(clk), .rst(rst), .d_i(pad_data_2), .q_o(data2_sync));

  assign start = (state_q == IDLE) && ((timer_q == '0) || poll_req);

`ifdef JOYPAD_DEBOUNCE_EN
  logic [NUM_BUTTONS-1:0] raw1_q, raw2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      raw1_q <= '0;
      raw2_q <= '0;
    end else if (state_q == DONE) begin
      raw1_q <= sh1_q;
      raw2_q <= sh2_q;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PH_W'(1);
    bit_d   = bit_q;
    timer_d = timer_q - CNT_W'(1);
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    if (start) begin
      timer_d = POLL_RELOAD;
    end
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = LATCH;
          bit_d   = 3'd0;
        end
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          // Pads present active-low data; store pressed as 1, LSB-first.
          sh1_d   = {~data1_sync, sh1_q[NUM_BUTTONS-1:1]};
          sh2_d   = {~data2_sync, sh2_q[NUM_BUTTONS-1:1]};
          bit_d   = bit_q + 3'd1;
          phase_d = '0;
          state_d = CLK_LO;
        end
      end
      CLK_LO: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          state_d = CLK_HI;
        end
      end
      CLK_HI: begin
        if (phase_q == PULSE_LAST) begin
          sh1_d   = {~data1_sync, sh1_q[NUM_BUTTONS-1:1]};
          sh2_d   = {~data2_sync, sh2_q[NUM_BUTTONS-1:1]};
          bit_d   = bit_q + 3'd1;
          phase_d = '0;
          state_d = (bit_q == 3'd7) ? DONE : CLK_LO;
        end
      end
      DONE: begin
`ifdef JOYPAD_DEBOUNCE_EN
        if (sh1_q == raw1_q) joy1_d = sh1_q;
        if (sh2_q == raw2_q) joy2_d = sh2_q;
`else
        joy1_d = sh1_q;
        joy2_d = sh2_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= 3'd0;
      timer_q <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      joy1_q  <= '0;
      joy2_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
    end
  end

  assign pad_latch = (state_q == LATCH);
  assign pad_clk   = (state_q != CLK_LO);
  assign busy      = (state_q != IDLE);
  assign valid     = (state_q == DONE);
  assign joycon_1  = joy1_q;
  assign joycon_2  = joy2_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_joypad_reader.sv
// ============================================================================
// Module : tb_nes_joypad_reader
// Brief  : Self-checking bench with 4021-style pad models and a button model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nes_joypad_reader;

  localparam int P    = 4;
  localparam int POLL = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_req = 1'b0;
  logic       pad_data_1, pad_data_2;
  logic       pad_latch, pad_clk, busy, valid;
  logic [7:0] joycon_1, joycon_2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  nes_joypad_reader #(.PULSE_CYCLES(P), .POLL_CYCLES(POLL), .CNT_W(19)) dut (
    .clk(clk), .rst(rst), .poll_req(poll_req),
    .pad_data_1(pad_data_1), .pad_data_2(pad_data_2),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .joycon_1(joycon_1), .joycon_2(joycon_2),
    .busy(busy), .valid(valid)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4021 pads: parallel load while latch is high, shift toward Q8 on pad_clk rise.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] sh1 = 8'hFF, sh2 = 8'hFF;
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) begin
      sh1 <= ~btn1;
      sh2 <= ~btn2;
    end else begin
      sh1 <= {1'b1, sh1[7:1]};
      sh2 <= {1'b1, sh2[7:1]};
    end
  end
  assign pad_data_1 = sh1[0];
  assign pad_data_2 = sh2[0];

  // Button model: what joycon_* should show after each completed poll.
  logic [7:0] exp1, exp2, raw1, raw2;

  task automatic model_reset();
    exp1 = 8'h00; exp2 = 8'h00; raw1 = 8'h00; raw2 = 8'h00;
  endtask

  task automatic model_poll(input logic [7:0] b1, input logic [7:0] b2);
`ifdef JOYPAD_DEBOUNCE_EN
    if (b1 == raw1) exp1 = b1;
    if (b2 == raw2) exp2 = b2;
    raw1 = b1;
    raw2 = b2;
`else
    exp1 = b1;
    exp2 = b2;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int  last_valid_cyc;

  // Observes one poll from the current negedge (cycle 0) through valid, then one more cycle.
  task automatic run_poll(input bit use_req, input int busy_req_at,
                          output int latch_n, output int lo_n, output bit pulse_ok,
                          output int valid_at, output int busy_n, output bit held_ok);
    int  i      = 0;
    int  lo_len = 0;
    bit  done   = 0;
    latch_n = 0; lo_n = 0; pulse_ok = 1; valid_at = -1; busy_n = 0; held_ok = 1;
    if (use_req) poll_req = 1'b1;
    while (!done && i < 400) begin
      @(negedge clk);
      i++;
      if (pad_latch) latch_n++;
      if (busy) busy_n++;
      poll_req = (busy_req_at != 0) && busy && (busy_n == busy_req_at);
      if (!pad_clk) lo_len++;
      else if (lo_len != 0) begin
        lo_n++;
        if (lo_len != P) pulse_ok = 0;
        lo_len = 0;
      end
      if (joycon_1 !== exp1 || joycon_2 !== exp2) held_ok = 0;
      if (valid) begin
        valid_at = i;
        last_valid_cyc = cyc;
        done = 1;
      end
    end
    poll_req = 1'b0;
    chk("valid_seen", {31'd0, done}, 32'd1);
    model_poll(btn1, btn2);
    @(negedge clk);
  endtask

  int  ln, lo, va, bn, v1, v2, v3, v4;
  bit  pok, hok;
  logic [7:0] deb_exp [3];
  logic [7:0] deb_in  [3];

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_latch", {31'd0, pad_latch}, 32'd0);
    chk("rst_clk",   {31'd0, pad_clk},   32'd1);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_valid", {31'd0, valid},     32'd0);
    chk("rst_joy1",  {24'd0, joycon_1},  32'd0);
    chk("rst_joy2",  {24'd0, joycon_2},  32'd0);

    // First poll starts on its own once reset is released.
    rst = 1'b0;
    run_poll(0, 0, ln, lo, pok, va, bn, hok);
    chk("p0_latch_cycles", ln, 8);
    chk("p0_clk_pulses",   lo, 7);
    chk("p0_pulse_len",    {31'd0, pok}, 32'd1);
    chk("p0_valid_at",     va, 16 * P + 1);
    chk("p0_busy_cycles",  bn, 16 * P + 1);
    chk("p0_held",         {31'd0, hok}, 32'd1);
    chk("p0_joy1",         {24'd0, joycon_1}, {24'd0, exp1});
    chk("p0_joy2",         {24'd0, joycon_2}, {24'd0, exp2});
    chk("idle_pads_zero",  {16'd0, joycon_1, joycon_2}, 32'd0);

    // A+Start on pad 1, Right on pad 2, by request.
    btn1 = 8'h09; btn2 = 8'h80;
    run_poll(1, 0, ln, lo, pok, va, bn, hok);
    chk("p1_valid_at", va, 16 * P + 1);
    chk("p1_held",     {31'd0, hok}, 32'd1);
    chk("p1_joy1",     {24'd0, joycon_1}, {24'd0, exp1});
    chk("p1_joy2",     {24'd0, joycon_2}, {24'd0, exp2});
`ifndef JOYPAD_DEBOUNCE_EN
    chk("p1_joy1_const", {24'd0, joycon_1}, 32'h09);
    chk("p1_joy2_const", {24'd0, joycon_2}, 32'h80);
`endif
    v1 = last_valid_cyc;

    // Auto poll, with a request injected while busy that must be dropped.
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    run_poll(0, 20, ln, lo, pok, va, bn, hok);
    v2 = last_valid_cyc;
    chk("auto_gap_1", v2 - v1, POLL);
    chk("p2_joy1", {24'd0, joycon_1}, {24'd0, exp1});
    chk("p2_joy2", {24'd0, joycon_2}, {24'd0, exp2});
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    run_poll(0, 0, ln, lo, pok, va, bn, hok);
    v3 = last_valid_cyc;
    chk("auto_gap_2", v3 - v2, POLL);
    chk("p3_joy1", {24'd0, joycon_1}, {24'd0, exp1});

    // Request in IDLE restarts the period from the request.
    repeat (50) @(negedge clk);
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    run_poll(1, 0, ln, lo, pok, va, bn, hok);
    v4 = last_valid_cyc;
    chk("req_valid_delay", v4 - v3, 1 + 50 + 16 * P + 1);
    chk("p4_joy2", {24'd0, joycon_2}, {24'd0, exp2});
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    run_poll(0, 0, ln, lo, pok, va, bn, hok);
    chk("reload_gap", last_valid_cyc - v4, POLL);

    for (int k = 0; k < 4; k++) begin
      btn1 = 8'($urandom); btn2 = 8'($urandom);
      run_poll(k[0], 0, ln, lo, pok, va, bn, hok);
      chk("rand_held", {31'd0, hok}, 32'd1);
      chk("rand_joy",  {16'd0, joycon_1, joycon_2}, {16'd0, exp1, exp2});
    end

    // Reset during the fourth low pad_clk pulse.
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    repeat (33) @(negedge clk);
    chk("mid_in_clk_lo", {31'd0, pad_clk}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("mid_rst_clk",   {31'd0, pad_clk},   32'd1);
    chk("mid_rst_latch", {31'd0, pad_latch}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    chk("mid_rst_joy",   {16'd0, joycon_1, joycon_2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_poll(0, 0, ln, lo, pok, va, bn, hok);
    chk("post_rst_valid_at", va, 16 * P + 1);
    chk("post_rst_pulses",   lo, 7);
    chk("post_rst_joy",      {16'd0, joycon_1, joycon_2}, {16'd0, exp1, exp2});

    // Debounce sequence from a clean history.
    rst = 1'b1;
    btn1 = 8'h00; btn2 = 8'h00;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    run_poll(0, 0, ln, lo, pok, va, bn, hok);
    deb_in[0] = 8'h01; deb_in[1] = 8'h02; deb_in[2] = 8'h02;
`ifdef JOYPAD_DEBOUNCE_EN
    deb_exp[0] = 8'h00; deb_exp[1] = 8'h00; deb_exp[2] = 8'h02;
`else
    deb_exp[0] = 8'h01; deb_exp[1] = 8'h02; deb_exp[2] = 8'h02;
`endif
    for (int k = 0; k < 3; k++) begin
      btn1 = deb_in[k];
      run_poll(1, 0, ln, lo, pok, va, bn, hok);
      chk("seq_joy1", {24'd0, joycon_1}, {24'd0, deb_exp[k]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nes_joypad_reader.md
Name: nes_joypad_reader

Overview:
- Host end of the NES controller serial protocol: drives latch/clock to two physical 4021-based pads and shifts their serial data back in.
- Presents parallel `joycon_1` / `joycon_2` bytes with the same bit meaning mem_ctrl already consumes, replacing the DIP-switch hookup.
- Sits in the 25 MHz `clk` domain beside mem_ctrl; polls autonomously once per frame period or on request.

Parameters:
- PULSE_CYCLES, 150, half-period of pad clock in `clk` cycles (6 us at 25 MHz); latch high lasts 2*PULSE_CYCLES.
- POLL_CYCLES, 416667, cycles between automatic poll starts (~60 Hz).
- CNT_W, 19, width of poll timer; must hold POLL_CYCLES.

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- poll_req  in  1  one-cycle request to start a poll immediately
- pad_data_1  in  1  serial data from pad 1, asynchronous, active-low (0 = pressed)
- pad_data_2  in  1  serial data from pad 2, asynchronous, active-low
- pad_latch  out  1  parallel-load strobe to both pads, active-high
- pad_clk  out  1  shift clock to both pads, idles high
- joycon_1  out  8  pad 1 buttons, 1 = pressed
- joycon_2  out  8  pad 2 buttons, 1 = pressed
- busy  out  1  high while a poll is in progress
- valid  out  1  one-cycle pulse when joycon outputs update

Behaviour:
- Reset values:
  - `joycon_1` = `joycon_2` = 8'h00; `pad_latch` = 0; `pad_clk` = 1; `busy` = 0; `valid` = 0.
  - Poll timer = 0, state IDLE, bit index = 0.
- Synchronization: `pad_data_*` pass through a 2-flop synchronizer. The synchronizer lag of 2 cycles is well inside the PULSE_CYCLES settling time, so PULSE_CYCLES >= 4 is required.
- Bit mapping (shift order): bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right. The stored value is the inverted synchronized data.
- Poll timer:
  - Free-running.
  - A poll starts in IDLE when the timer == 0 or `poll_req` = 1; the timer reloads to POLL_CYCLES-1 on every poll start.
  - The first poll therefore starts on the first cycle after `rst` deasserts.
- States:
  - IDLE: `pad_latch` = 0, `pad_clk` = 1, `busy` = 0. On start -> LATCH, phase counter cleared.
  - LATCH: `pad_latch` = 1 for 2*PULSE_CYCLES cycles. On the last cycle, sample bit0 of both pads into shift registers, then -> CLK_LO.
  - CLK_LO: `pad_latch` = 0, `pad_clk` = 0 for PULSE_CYCLES cycles, then -> CLK_HI. The pad shifts on the rising edge.
  - CLK_HI: `pad_clk` = 1 for PULSE_CYCLES cycles. On the last cycle, sample the next bit.
    - If 8 bits have been sampled -> DONE.
    - Else -> CLK_LO.
  - DONE: one cycle. Copy shift registers to `joycon_*`, `valid` = 1, -> IDLE.
- Timing:
  - Poll duration from start to `valid` = 16*PULSE_CYCLES + 1 cycles.
  - Exactly 7 low pulses on `pad_clk` per poll.
  - `busy` is high in LATCH..DONE inclusive.
- Boundary cases:
  - `poll_req` or timer expiry while busy: ignored, not queued. The timer keeps counting and reloads only on an actual start.
  - Timer == 0 and `poll_req` in the same IDLE cycle: a single poll starts.
  - `joycon_*` hold their previous value throughout a poll; there are no partial updates.
  - `rst` mid-poll: all outputs return to reset values next cycle, `joycon_*` cleared, and the partial shift data is discarded.
  - Disconnected pad (data pulled high): reads 8'h00.

Optional Feature:
- Macro: JOYPAD_DEBOUNCE_EN.
- Defined: each pad keeps the previous raw sample. In DONE, `joycon_N` updates only if the new sample equals the previous poll's raw sample; otherwise it holds. `valid` still pulses every poll.
- Not defined: `joycon_N` updates every poll, as described above.

Decomposition:
- Package `nes_joypad_pkg`:
  - State enum (IDLE, LATCH, CLK_LO, CLK_HI, DONE).
  - Button index constants BTN_A..BTN_RIGHT (0..7).
  - NUM_BUTTONS = 8.
- Sub-module `sync_2ff`: one-bit two-flop synchronizer with synchronous reset to 1, instantiated once per pad. The FSM, timer and shift registers stay in the top block.

Test Plan (PULSE_CYCLES=4, POLL_CYCLES=200 unless noted):
- Reset release, both pads idle high -> poll starts on the cycle after reset; `pad_latch` high 8 cycles; 7 `pad_clk` low pulses of 4 cycles; `valid` at cycle 65 after start; `joycon_1` = `joycon_2` = 8'h00.
- Pad models (4021 behaviour) loaded with pad1 = A+Start, pad2 = Right -> `joycon_1` = 8'h09, `joycon_2` = 8'h80 after `valid`; outputs unchanged before `valid`.
- No `poll_req` -> successive `valid` pulses exactly 200 cycles apart. `poll_req` during a busy poll -> no extra poll. `poll_req` in IDLE -> LATCH next cycle and timer reloaded.
- `rst` asserted in CLK_LO of bit 4 -> next cycle `pad_clk` = 1, `pad_latch` = 0, `busy` = 0, `joycon_*` = 0; a new full poll runs after release.
- With JOYPAD_DEBOUNCE_EN, pad1 returns 8'h01 then 8'h02 then 8'h02 on successive polls -> `joycon_1` = 8'h00, 8'h00, 8'h02; without the macro -> 8'h01, 8'h02, 8'h02.
